vid_line_capture: RTL

Captures the ZX-side 15-bit RGB video bus (5:5:5, with HS/VS) on the pixel clock, writes the active window into a ping-pong line buffer and replays it to the HDMI/DVI encoder against the encoder's `cx`/`cy` raster coordinates. It sits directly upstream of the `hdmi` encoder, replacing the direct bus-to-`rgb` wiring. A lock state machine qualifies the source timing; while unlocked, the block outputs a fixed no-signal colour.

---
 rtl/vid_pkg.sv | 28 ++
 rtl/vid_line_capture_if.sv | 26 ++
 rtl/vid_line_ram.sv | 47 ++++
 rtl/vid_line_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and helpers for the ZX video line capture path.
// The source delivers 5:5:5 RGB. The encoder expects 8:8:8.
package vid_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb15_t;

  localparam logic [23:0] NO_SIGNAL_RGB = 24'h0000C0;

  // Top bits are replicated into the low bits so that full scale maps to 8'hFF.
  function automatic logic [7:0] expand5to8(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [23:0] expand_rgb(input rgb15_t p);
    return {expand5to8(p.r), expand5to8(p.g), expand5to8(p.b)};
  endfunction

endpackage

// File: rtl/vid_line_capture_if.sv
// Source video bus plus the encoder raster/colour side of the line capture block.
// The master drives the source pixels and raster position. The slave returns the colour and lock status.
interface vid_line_capture_if;

  logic [4:0]  vid_r;
  logic [4:0]  vid_g;
  logic [4:0]  vid_b;
  logic        vid_hs;
  logic        vid_vs;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [23:0] rgb;
  logic        locked;
  logic [9:0]  lines_per_frame;

  modport master (
    output vid_r, vid_g, vid_b, vid_hs, vid_vs, cx, cy,
    input  rgb, locked, lines_per_frame
  );

  modport slave (
    input  vid_r, vid_g, vid_b, vid_hs, vid_vs, cx, cy,
    output rgb, locked, lines_per_frame
  );

endinterface

// File: rtl/vid_line_ram.sv
// Ping-pong line store: two banks of DEPTH_PER_BANK 15-bit pixels. Writes are synchronous and reads are registered.
// Read latency is 1 cycle and there is no backpressure. Read and write may hit the same bank in the same cycle.
module vid_line_ram
  import vid_pkg::*;
#(
  parameter int unsigned DEPTH_PER_BANK = 720,
  parameter int unsigned IDX_W          = 10
) (
  input  logic             clk_pixel,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  rgb15_t           wr_dat_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output rgb15_t           rd_dat_o
);

  localparam int unsigned DEPTH = 2 * DEPTH_PER_BANK;
  localparam int unsigned AW    = $clog2(DEPTH);

  rgb15_t        mem_q [DEPTH];
  rgb15_t        rd_dat_q;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Banks are packed back to back, so only 2*DEPTH_PER_BANK entries are stored.
  function automatic logic [AW-1:0] flat_addr(input logic bank, input logic [IDX_W-1:0] idx);
    return AW'(idx) + (bank ? AW'(DEPTH_PER_BANK) : AW'(0));
  endfunction

  assign wr_addr = flat_addr(wr_bank_i, wr_idx_i);
  assign rd_addr = flat_addr(rd_bank_i, rd_idx_i);

  always_ff @(posedge clk_pixel) begin
    if (wr_en_i) begin
      mem_q[wr_addr] <= wr_dat_i;
    end
    if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/vid_line_capture.sv
// Captures the 5:5:5 source video into a ping-pong line buffer and replays it against the encoder raster.
// Latency is 1 cycle from source pin to RAM write and 2 cycles from cx/cy to rgb. The stream is free-running with no backpressure.
module vid_line_capture
  import vid_pkg::*;
#(
  parameter int unsigned ACTIVE_W      = 720,
  parameter int unsigned ACTIVE_H      = 576,
  parameter int unsigned H_OFFSET      = 132,
  parameter int unsigned V_OFFSET      = 44,
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned TIMEOUT_W     = 12
) (
  input  logic              clk_pixel,
  input  logic              reset,
  vid_line_capture_if.slave bus
);

  localparam logic [9:0]           CNT_MAX  = 10'h3FF;
  localparam logic [9:0]           X_LO     = 10'(H_OFFSET);
  localparam logic [9:0]           X_HI     = 10'(H_OFFSET + ACTIVE_W);
  localparam logic [9:0]           Y_LO     = 10'(V_OFFSET);
  localparam logic [9:0]           Y_HI     = 10'(V_OFFSET + ACTIVE_H);
  localparam logic [9:0]           RD_W     = 10'(ACTIVE_W);
  localparam logic [9:0]           RD_H     = 10'(ACTIVE_H);
  localparam logic [TIMEOUT_W-1:0] IDLE_MAX = '1;

  rgb15_t pix_s1_q;
  logic   hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
  logic   hs_edge, vs_edge;

  logic [9:0]           x_q, x_d, x_cnt;
  logic [9:0]           y_q, y_cnt;
  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 timeout;

  lock_state_t state_q, state_d;
  logic [9:0]  lpf_q, lpf_d;

  logic       wr_en;
  logic [9:0] wr_idx;
  logic       rd_in_win;
  rgb15_t     rd_dat;
  logic       win_s1_q, lock_s1_q;
  logic [23:0] rgb_q, rgb_d;

  // Source input stage. Syncs reset to their idle level so that a release never fakes an edge.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pix_s1_q <= '0;
      hs_s1_q  <= HS_ACTIVE_LOW;
      vs_s1_q  <= VS_ACTIVE_LOW;
      hs_s2_q  <= HS_ACTIVE_LOW;
      vs_s2_q  <= VS_ACTIVE_LOW;
    end else begin
      pix_s1_q <= {bus.vid_r, bus.vid_g, bus.vid_b};
      hs_s1_q  <= bus.vid_hs;
      vs_s1_q  <= bus.vid_vs;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
    end
  end

  assign hs_edge = (hs_s1_q ^ HS_ACTIVE_LOW) & ~(hs_s2_q ^ HS_ACTIVE_LOW);
  assign vs_edge = (vs_s1_q ^ VS_ACTIVE_LOW) & ~(vs_s2_q ^ VS_ACTIVE_LOW);

  // x_cnt and y_cnt are the coordinates of the s1 pixel in the current cycle.
  always_comb begin
    x_cnt = hs_edge ? 10'd0 : x_q;
    x_d   = (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 10'd1;

    if (vs_edge) begin
      y_cnt = 10'd0;
    end else if (hs_edge && (y_q != CNT_MAX)) begin
      y_cnt = y_q + 10'd1;
    end else begin
      y_cnt = y_q;
    end

    // idle_q holds the number of cycles since the last hs_edge.
    if (hs_edge) begin
      idle_d = TIMEOUT_W'(1);
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + TIMEOUT_W'(1);
    end

    rd_bank_d = rd_bank_q;
    if (hs_edge && (y_q >= Y_LO) && (y_q < Y_HI)) begin
      rd_bank_d = y_q[0];
    end
  end

  assign timeout = (idle_q == IDLE_MAX) && !hs_edge;

  always_comb begin
    state_d = state_q;
    lpf_d   = lpf_q;
    if (timeout) begin
      state_d = SEARCH;
    end else if (vs_edge) begin
      case (state_q)
        SEARCH: state_d = MEASURE;
        MEASURE: begin
          lpf_d = y_q;
          if (y_q >= Y_HI) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (y_q != lpf_q) begin
            lpf_d   = y_q;
            state_d = MEASURE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      idle_q    <= '0;
      rd_bank_q <= 1'b0;
      state_q   <= SEARCH;
      lpf_q     <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_cnt;
      idle_q    <= idle_d;
      rd_bank_q <= rd_bank_d;
      state_q   <= state_d;
      lpf_q     <= lpf_d;
    end
  end

  assign wr_en     = (x_cnt >= X_LO) && (x_cnt < X_HI) && (y_cnt >= Y_LO) && (y_cnt < Y_HI);
  assign wr_idx    = x_cnt - X_LO;
  assign rd_in_win = (bus.cx < RD_W) && (bus.cy < RD_H);

  vid_line_ram #(
    .DEPTH_PER_BANK (ACTIVE_W),
    .IDX_W          (10)
  ) u_line_ram (
    .clk_pixel (clk_pixel),
    .wr_en_i   (wr_en),
    .wr_bank_i (y_cnt[0]),
    .wr_idx_i  (wr_idx),
    .wr_dat_i  (pix_s1_q),
    .rd_en_i   (rd_in_win),
    .rd_bank_i (rd_bank_q),
    .rd_idx_i  (bus.cx),
    .rd_dat_o  (rd_dat)
  );

  // The window and lock qualifiers travel alongside the RAM read so that all three line up at rgb.
  always_comb begin
    rgb_d = NO_SIGNAL_RGB;
    if (lock_s1_q) begin
      rgb_d = win_s1_q ? expand_rgb(rd_dat) : 24'h000000;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      win_s1_q  <= 1'b0;
      lock_s1_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      win_s1_q  <= rd_in_win;
      lock_s1_q <= (state_q == LOCKED);
      rgb_q     <= rgb_d;
    end
  end

  assign bus.rgb             = rgb_q;
  assign bus.locked          = (state_q == LOCKED);
  assign bus.lines_per_frame = lpf_q;

endmodule
